uart_rx: RTL and testbench

- UART receiver with 16x oversampling, 8N1 framing.
- Converts the serial line from the host PC into bytes for the debug unit, which loads MIPS instruction memory and sends run and step commands.
- Sits directly upstream of the debug unit, driving its rx-data and rx-ready inputs, and is cleared by the debug unit's rx-reset output.
- Runs on the same clock as MIPS, the debug unit and tx.

---
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, 16x oversampled, feeding bytes to the debug unit.
// Latency: o_rx_ready rises ~2 + (8 + 16*DBIT + SB_TICK)*DIV cycles after the start edge.
// Backpressure: none; o_rx_ready is held until i_rx_reset, a newer byte overwrites and sets o_overrun.
// Ports: i_clk clock, i_reset async active-low reset, i_rx serial line (idle high, async),
//        i_rx_reset clears ready/overrun/frame_err, o_rx_data last byte, o_rx_ready byte valid,
//        o_frame_err sticky bad stop bit, o_overrun sticky byte lost.
module uart_rx #(
    parameter int CLK_FR      = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DBIT        = 8,
    parameter int RX_DIV_SAMP = 16,
    parameter int SB_TICK     = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_rx_reset,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_ready,
    output logic            o_frame_err,
    output logic            o_overrun
);

    localparam int DIV   = CLK_FR / (BAUD_RATE * RX_DIV_SAMP);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_MAX = (RX_DIV_SAMP > SB_TICK) ? RX_DIV_SAMP : SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID       = S_W'(RX_DIV_SAMP / 2 - 1);
    localparam logic [S_W-1:0]   S_BIT_LAST  = S_W'(RX_DIV_SAMP - 1);
    localparam logic [S_W-1:0]   S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]   N_LAST      = N_W'(DBIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rx_meta_q, rx_s_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;
    logic [1:0]       state_q, state_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [DBIT-1:0]  b_q, b_d;
    logic             armed_q, armed_d;
    logic             done_ok, done_err;
    logic [DBIT-1:0]  rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Free-running oversample tick generator.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        armed_d  = armed_q;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a high-to-low transition starts a frame: a held-low
                // line (break, or a failed stop bit) must go high first.
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d  = IDLE;
                        s_d      = '0;
                        done_ok  = rx_s_q;
                        done_err = !rx_s_q;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flags: a completing byte takes priority over a same-cycle clear,
    // but that clear still suppresses the overrun the old byte would cause.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_ready_d  = rx_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_rx_reset) begin
            rx_ready_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (done_ok) begin
            rx_data_d  = b_q;
            rx_ready_d = 1'b1;
            overrun_d  = overrun_d | (rx_ready_q & !i_rx_reset);
        end
        if (done_err) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            armed_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_rx_data   = rx_data_q;
    assign o_rx_ready  = rx_ready_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx at DIV=10 (160 clocks per bit).
// Latency: frames take 1600 clocks plus a short idle gap.
// Backpressure: i_rx_reset pulses emulate the debug unit consuming bytes.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_reset;
    logic [7:0] o_data;
    logic       o_rdy;
    logic       o_ferr;
    logic       o_ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_rx #(
        .CLK_FR     (1600000),
        .BAUD_RATE  (10000),
        .DBIT       (8),
        .RX_DIV_SAMP(16),
        .SB_TICK    (16)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_rx       (rx),
        .i_rx_reset (rx_reset),
        .o_rx_data  (o_data),
        .o_rx_ready (o_rdy),
        .o_frame_err(o_ferr),
        .o_overrun  (o_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter aligned with the DUT's reset, used only to repeat a tick phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       pulse;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_ferr;
        logic       e_ovr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drives the first nbits of {stop, data, start} LSB first, 160 clocks each.
    task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, stop, 10);
        rx = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx_reset();
        @(posedge clk); #1 rx_reset = 1'b1;
        @(posedge clk); #1 rx_reset = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] d, input logic r,
                           input logic f, input logic v);
        @(negedge clk);
        chk({nm, ".data"}, {24'd0, o_data}, {24'd0, d});
        chk({nm, ".ready"}, {31'd0, o_rdy}, {31'd0, r});
        chk({nm, ".ferr"}, {31'd0, o_ferr}, {31'd0, f});
        chk({nm, ".ovr"}, {31'd0, o_ovr}, {31'd0, v});
    endtask

    task automatic align_phase();
        do begin
            @(posedge clk); #1;
        end while (cyc % 10 != 3);
    endtask

    // Reference model: byte-level receiver state.
    logic [7:0] m_data;
    logic       m_rdy, m_ferr, m_ovr;

    initial begin
        int lat;
        int l_meas;
        logic [7:0] d;
        logic st, pl;

        tbl[0]  = '{8'h64, 1'b1, 1'b1, 8'h64, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8'h20, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{8'h63, 1'b1, 1'b1, 8'h63, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{8'h3C, 1'b0, 1'b0, 8'h63, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'h7E, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0};

        rx = 1'b1;
        rx_reset = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Latency of the first frame, measured from the start-bit edge.
        lat = 0;
        fork
            send_frame(8'h64, 1'b1);
            begin
                @(negedge clk);
                while (!o_rdy && lat < 2000) begin
                    @(posedge clk); lat++;
                    @(negedge clk);
                end
            end
        join
        chk("latency_in_window", {31'd0, (lat >= 1508 && lat <= 1532)}, 32'd1);
        chk_all("first_frame", 8'h64, 1'b1, 1'b0, 1'b0);
        pulse_rx_reset();

        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].din, tbl[i].stop);
            chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_rdy, tbl[i].e_ferr, tbl[i].e_ovr);
            if (tbl[i].pulse) begin
                pulse_rx_reset();
                chk_all($sformatf("vec%0d_clr", i), tbl[i].e_data, 1'b0, 1'b0, 1'b0);
            end
        end

        // Glitch shorter than half a bit must be ignored.
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk_all("glitch", 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1);
        chk_all("after_glitch", 8'hA5, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the data bits, with ready already set.
        send_bits(8'h55, 1'b1, 5);
        rst_n = 1'b0;
        #1;
        chk("midreset.data", {24'd0, o_data}, 32'd0);
        chk("midreset.ready", {31'd0, o_rdy}, 32'd0);
        chk("midreset.ovr", {31'd0, o_ovr}, 32'd0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1);
        chk_all("post_reset_frame", 8'h55, 1'b1, 1'b0, 1'b0);
        pulse_rx_reset();

        // Measure completion edge at a fixed tick phase, then land i_rx_reset on it.
        align_phase();
        l_meas = 0;
        fork
            send_frame(8'h3A, 1'b1);
            begin
                @(negedge clk);
                while (!o_rdy && l_meas < 2000) begin
                    @(posedge clk); l_meas++;
                    @(negedge clk);
                end
            end
        join
        chk("aligned_latency", {31'd0, (l_meas >= 1508 && l_meas <= 1532)}, 32'd1);
        chk_all("aligned_frame", 8'h3A, 1'b1, 1'b0, 1'b0);
        if (l_meas < 2 || l_meas > 1600) l_meas = 1520;
        align_phase();
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (l_meas - 1) @(posedge clk);
                #1 rx_reset = 1'b1;
                @(posedge clk);
                #1 rx_reset = 1'b0;
            end
        join
        chk_all("coincident", 8'h99, 1'b1, 1'b0, 1'b0);
        pulse_rx_reset();
        chk_all("coincident_clr", 8'h99, 1'b0, 1'b0, 1'b0);

        // Randomized frames against the byte-level model.
        m_data = 8'h99; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            pl = 1'($urandom_range(0, 1));
            send_frame(d, st);
            if (st) begin
                m_ovr  = m_ovr | m_rdy;
                m_rdy  = 1'b1;
                m_data = d;
            end else begin
                m_ferr = 1'b1;
            end
            chk_all($sformatf("rnd%0d", i), m_data, m_rdy, m_ferr, m_ovr);
            if (pl) begin
                pulse_rx_reset();
                m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
                chk_all($sformatf("rnd%0d_clr", i), m_data, m_rdy, m_ferr, m_ovr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
